// File: rtl/strgen.sv
// strgen -- keyword stream generator.
//
// Emits [filler x gap, KEYWORD] repeated ins_cnt times followed by one
// trailing run of gap filler bytes, over a valid/ready byte interface.
// Filler bytes are 'a'..'p', taken from an 8-bit LFSR that is reseeded
// on every accepted start. This keeps each stream reproducible, and the
// fillers can never form a keyword.
//
// Ports
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  stream request, sampled only while idle
//   ins_cnt  in   4  keyword insertions, latched on accepted start
//   gap      in   8  filler bytes per gap, latched on accepted start
//   ready    in   1  downstream accepts the current byte
//   dv       out  1  data valid
//   data     out  8  stream byte
//   busy     out  1  stream in progress (through the done cycle)
//   done     out  1  one-cycle end-of-stream pulse
//
// state | meaning
// IDLE  | waiting for start
// GAP   | presenting filler bytes
// KEY   | presenting keyword bytes, MSB first
// FIN   | done pulse, back to IDLE next cycle

module strgen #(
  parameter int                    KEY_LEN = 7,
  parameter logic [KEY_LEN*8-1:0]  KEYWORD = "Welcome"
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] ins_cnt,
  input  logic [7:0] gap,
  input  logic       ready,
  output logic       dv,
  output logic [7:0] data,
  output logic       busy,
  output logic       done
);

  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [KW-1:0] KEY_LAST = KW'(KEY_LEN - 1);
  localparam logic [7:0]    LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {IDLE, GAP, KEY, FIN} state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [3:0]    ins_rem_q, ins_rem_d;
  logic [7:0]    gap_len_q, gap_len_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic [KW-1:0] key_idx_q, key_idx_d;

  logic [7:0] lfsr_step;
  logic [7:0] key_byte;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  // key_idx counts down, so the first byte sent is the MSB byte
  assign key_byte  = KEYWORD[{key_idx_q, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      ins_rem_q <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      key_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      ins_rem_q <= ins_rem_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      key_idx_q <= key_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    ins_rem_d = ins_rem_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    key_idx_d = key_idx_q;
    dv        = 1'b0;
    data      = 8'h00;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          lfsr_d    = LFSR_SEED;
          ins_rem_d = ins_cnt;
          gap_len_d = gap;
          gap_cnt_d = gap;
          key_idx_d = KEY_LAST;
          if (gap != 8'd0)          state_d = GAP;
          else if (ins_cnt != 4'd0) state_d = KEY;
          else                      state_d = FIN;
        end
      end

      GAP: begin
        dv   = 1'b1;
        data = 8'h61 + {4'h0, lfsr_q[3:0]};
        if (ready) begin
          lfsr_d = lfsr_step;
          // gap_cnt holds the fillers still to send, including this one
          if (gap_cnt_q == 8'd1) begin
            if (ins_rem_q != 4'd0) begin
              state_d   = KEY;
              key_idx_d = KEY_LAST;
            end else begin
              state_d = FIN;
            end
          end else begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end
      end

      KEY: begin
        dv   = 1'b1;
        data = key_byte;
        if (ready) begin
          if (key_idx_q == '0) begin
            ins_rem_d = ins_rem_q - 4'd1;
            if (gap_len_q != 8'd0) begin
              state_d   = GAP;
              gap_cnt_d = gap_len_q;
            end else if (ins_rem_q != 4'd1) begin
              state_d   = KEY;
              key_idx_d = KEY_LAST;
            end else begin
              state_d = FIN;
            end
          end else begin
            key_idx_d = key_idx_q - KW'(1);
          end
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_strgen.sv
module tb_strgen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] ins_cnt = '0;
  logic [7:0] gap = '0;
  logic       ready = 1'b0;
  logic       dv;
  logic [7:0] data;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [55:0] KW_STR = "Welcome";
  localparam int BUDGET = 4000;

  byte unsigned exp_q[$];
  byte unsigned got_q[$];

  strgen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ins_cnt(ins_cnt), .gap(gap),
    .ready(ready), .dv(dv), .data(data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic byte unsigned kw_byte(input int i);
    logic [55:0] k;
    k = KW_STR;
    return k[(6 - i) * 8 +: 8];
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Golden stream straight from the stream-order rule
  task automatic build_expected(input int ins, input int gp);
    logic [7:0] l;
    l = 8'hA5;
    exp_q.delete();
    for (int i = 0; i <= ins; i++) begin
      for (int g = 0; g < gp; g++) begin
        exp_q.push_back(8'h61 + {4'h0, l[3:0]});
        l = lfsr_next(l);
      end
      if (i < ins)
        for (int k = 0; k < 7; k++) exp_q.push_back(kw_byte(k));
    end
  endtask

  function automatic int count_keyword();
    int n;
    bit hit;
    n = 0;
    for (int i = 0; i + 7 <= got_q.size(); i++) begin
      hit = 1'b1;
      for (int k = 0; k < 7; k++)
        if (got_q[i + k] != kw_byte(k)) hit = 1'b0;
      if (hit) n++;
    end
    return n;
  endfunction

  task automatic run_stream(input string tag, input int ins, input int gp, input int ready_pct);
    int cycle, last_xfer, stable_err, busy_err, data_err;
    bit seen_done, prev_stall;
    logic [7:0] prev_data;

    build_expected(ins, gp);
    got_q.delete();
    @(negedge clk);
    start = 1'b1; ins_cnt = 4'(ins); gap = 8'(gp);
    @(negedge clk);
    // post-acceptance changes to the inputs must not matter
    ins_cnt = 4'($urandom); gap = 8'($urandom);
    cycle = 0; last_xfer = -1; stable_err = 0; busy_err = 0;
    seen_done = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;

    while (!seen_done && cycle < BUDGET) begin
      start = 1'($urandom_range(1));
      ready = ($urandom_range(99) < ready_pct);
      if (busy !== 1'b1) busy_err++;
      if (cycle == 0) chk({tag, " first dv"}, dv, (exp_q.size() != 0));
      if (prev_stall && (dv !== 1'b1 || data !== prev_data)) stable_err++;
      if (done === 1'b1) begin
        seen_done = 1'b1;
        chk({tag, " dv in done cycle"}, dv, 1'b0);
        chk({tag, " done timing"}, cycle, last_xfer + 1);
      end else if (dv === 1'b1 && ready) begin
        got_q.push_back(data);
        last_xfer = cycle;
      end
      prev_stall = (dv === 1'b1) && !ready;
      prev_data  = data;
      cycle++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " done seen"}, seen_done, 1'b1);
    chk({tag, " busy during stream"}, busy_err, 0);
    chk({tag, " stall stability"}, stable_err, 0);
    chk({tag, " byte count"}, got_q.size(), exp_q.size());
    data_err = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] != exp_q[i]) data_err++;
    chk({tag, " byte errors"}, data_err, 0);
    chk({tag, " keyword count"}, count_keyword(), ins);
    chk({tag, " idle busy"}, busy, 1'b0);
    chk({tag, " idle done"}, done, 1'b0);
    if (ready_pct == 100) chk({tag, " no bubbles"}, cycle, exp_q.size() + 1);
  endtask

  initial begin
    #3;
    chk("reset dv", dv, 1'b0);
    chk("reset data", data, 8'h00);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_stream("i1g2", 1, 2, 100);
    chk("i1g2 first filler", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h66);
    chk("i1g2 length", got_q.size(), 11);

    run_stream("i0g0", 0, 0, 100);
    run_stream("i3g0", 3, 0, 100);
    chk("i3g0 length", got_q.size(), 21);
    run_stream("i2g5", 2, 5, 50);
    chk("i2g5 length", got_q.size(), 29);

    // Reset while the 4th keyword byte ('c') is presented
    begin
      int n;
      bit hit;
      n = 0; hit = 1'b0;
      @(negedge clk);
      start = 1'b1; ins_cnt = 4'd1; gap = 8'd2;
      @(negedge clk);
      start = 1'b0; ready = 1'b1;
      for (int c = 0; c < 40 && !hit; c++) begin
        if (dv === 1'b1 && n == 5) begin
          hit = 1'b1;
          chk("mid-reset presented byte", data, 8'h63);
          #2 rst_n = 1'b0;
          #1;
          chk("mid-reset dv", dv, 1'b0);
          chk("mid-reset data", data, 8'h00);
          chk("mid-reset busy", busy, 1'b0);
          chk("mid-reset done", done, 1'b0);
        end else begin
          if (dv === 1'b1) n++;
          @(negedge clk);
        end
      end
      chk("mid-reset reached", hit, 1'b1);
      @(negedge clk);
      chk("held-reset done", done, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset done", done, 1'b0);
      chk("post-reset busy", busy, 1'b0);
    end
    run_stream("after reset", 1, 2, 100);
    chk("after reset first filler", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h66);

    for (int r = 0; r < 6; r++)
      run_stream($sformatf("rand%0d", r), $urandom_range(15), $urandom_range(20),
                 $urandom_range(30, 100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/strgen.md
STRGEN -- requirements
Module: strgen

Interface
REQ-001 Parameter KEY_LEN, default 7: keyword length in bytes.
REQ-002 Parameter KEYWORD, default "Welcome" (56 bits): keyword, first character in the MSB byte.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to generate one stream; sampled only in IDLE.
REQ-006 ins_cnt  input  4  number of keyword insertions, 0..15; latched on accepted start.
REQ-007 gap  input  8  filler bytes before each keyword and after the last one, 0..255; latched on accepted start.
REQ-008 ready  input  1  downstream accepts the current byte this cycle.
REQ-009 dv  output  1  data valid; data holds a byte to transfer.
REQ-010 data  output  8  stream byte.
REQ-011 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-012 done  output  1  one-cycle pulse at the end of the stream.

Function
REQ-013 Transfer: a byte moves only in a cycle with dv=1 and ready=1. While dv=1 and ready=0, data and dv hold stable.
REQ-014 FSM states: IDLE, GAP, KEY, FIN.
- IDLE->GAP on start when gap!=0.
- IDLE->KEY on start when gap=0 and ins_cnt!=0.
- IDLE->FIN on start when gap=0 and ins_cnt=0.
REQ-015 Stream order: [gap filler, KEYWORD] repeated ins_cnt times, then one trailing gap filler. Total bytes = (ins_cnt+1)*gap + ins_cnt*KEY_LEN.
REQ-016 GAP state: emits filler bytes and counts transfers up to the latched gap. After the last filler byte:
- go to KEY if insertions remain;
- otherwise go to FIN.
REQ-017 KEY state: emits KEYWORD bytes MSB-first, one per transfer. After the last keyword byte, decrement the remaining-insertion count, then:
- go to GAP if gap!=0;
- else go to KEY if insertions remain;
- else go to FIN.
REQ-018 FIN state: dv=0, done=1 for exactly one cycle, then return to IDLE.
REQ-019 Filler byte = 8'h61 + lfsr[3:0] (range 'a'..'p'). Fillers never contain 'W', so the stream holds exactly ins_cnt keyword occurrences.
REQ-020 LFSR:
- 8 bits, polynomial x^8+x^6+x^5+x^4+1, shifts toward MSB, feedback into bit 0.
- Loaded with 8'hA5 on reset and on every accepted start.
- Advances only on a filler-byte transfer.
REQ-021 Latency: with start accepted at edge n, dv=1 with the first byte after edge n+1. With ready held at 1, one byte transfers per cycle with no bubbles, including at GAP/KEY boundaries.
REQ-022 done asserts the cycle after the final byte transfer. For ins_cnt=0 and gap=0, done asserts the cycle after start, with no bytes sent.
REQ-023 A start while busy=1 is ignored. ins_cnt and gap changes after acceptance have no effect on the current stream.
REQ-024 ready may toggle on any cycle. A stall of any length loses, duplicates and reorders no bytes.

Reset
REQ-025 Asynchronous rst_n=0 forces, without waiting for a clock edge:
- FSM to IDLE;
- dv=0, data=8'h00, busy=0, done=0;
- counters to 0;
- LFSR to 8'hA5.
REQ-026 Reset mid-stream abandons the stream with no done pulse. After release, the block accepts a new start normally.
REQ-027 Reset release is synchronous to clk. The first start is accepted no earlier than the first edge after release.

Verification
REQ-028 ins_cnt=1, gap=2, ready=1 -> 11 bytes:
- first filler 'f' (lfsr A5, low nibble 5 -> 8'h66);
- then 1 filler, "Welcome", 2 fillers;
- done 1 cycle after byte 11.
REQ-029 ins_cnt=0, gap=0 -> dv stays 0, done pulses at edge n+1, busy high for exactly that cycle.
REQ-030 ins_cnt=3, gap=0, ready=1 -> 21 contiguous bytes "WelcomeWelcomeWelcome", no gaps, then done.
REQ-031 ins_cnt=2, gap=5, ready random 50% -> 29 bytes captured on dv&ready match the ready=1 golden sequence exactly, with data stable during every stall.
REQ-032 rst_n=0 while the 4th keyword byte is presented -> dv=0 immediately, no done. A new start yields a stream identical to a fresh run (filler sequence from 8'hA5).
REQ-033 Stream from REQ-031 fed into the string-search block -> search count equals ins_cnt.
